// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the D->X->M->W datapath.
//   op1/op2 operand selects, ALU result select, writeback select,
//   load funct3 encodings and the forwarding source select.
package proc_pkg;

  typedef enum logic {
    REG1_DATA = 1'b0,
    PC_VAL_D1 = 1'b1
  } op1_mux_sel_t;

  typedef enum logic {
    REG2_DATA  = 1'b0,
    IMM_SIGNED = 1'b1
  } op2_mux_sel_t;

  // Encodings 6 and 7 are undefined and produce a zero result.
  typedef enum logic [2:0] {
    ALU_ARITH            = 3'd0,
    ALU_LOGIC            = 3'd1,
    ALU_SHIFT            = 3'd2,
    ALU_X_OP1            = 3'd3,
    ALU_PC_VAL_D2        = 3'd4,
    ALU_PC_VAL_PLUS_4_D2 = 3'd5
  } alu_mux_sel_t;

  typedef enum logic [1:0] {
    W_ALU = 2'd0,
    W_DM  = 2'd1,
    W_CSR = 2'd2
  } w_mux_sel_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_X    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_sel_t;

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_D  = 3'b011;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;
  localparam logic [2:0] LOAD_WU = 3'b110;

endpackage

// File: rtl/load_align.sv
// load_align: combinational load lane select and sign/zero extension.
//   funct3 : load type (LB/LH/LW/LD/LBU/LHU/LWU, 111 reserved -> 0)
//   offset : byte offset within the data word
//   word   : raw data memory read word
//   data   : aligned, extended load result
module load_align
  import proc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            word,
  output logic [XLEN-1:0]            data
);

  localparam int BYTE_AW = $clog2(XLEN/8);

  logic [BYTE_AW-1:0] off_h;
  logic [BYTE_AW-1:0] off_w;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        lane_w;

  always_comb begin
    // Misalignment is trapped upstream, so low offset bits are simply dropped.
    off_h      = offset;
    off_h[0]   = 1'b0;
    off_w      = offset;
    off_w[1:0] = 2'b00;
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = word[{off_h, 3'b000} +: 16];
    lane_w = word[{off_w, 3'b000} +: 32];

    data = '0;
    case (funct3)
      LOAD_B:  data = XLEN'($signed(lane_b));
      LOAD_H:  data = XLEN'($signed(lane_h));
      LOAD_W:  data = XLEN'($signed(lane_w));
      // At XLEN=32 the whole word is the LW result, so LD is LW there.
      LOAD_D:  data = word;
      LOAD_BU: data = XLEN'(lane_b);
      LOAD_HU: data = XLEN'(lane_h);
      // At XLEN=32 zero- and sign-extension of a full word coincide.
      LOAD_WU: data = XLEN'(lane_w);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: D->X->M->W pipeline datapath.
//   D: operand selection with forwarding from X/M/W, captured into X.
//   X: ALU result select from external units, captured into M.
//   M: load alignment and writeback select, captured into W.
//   stall_i holds every stage; flush_i squashes D and X (valids of X/M
//   clear) while W still retires M. Outputs: X operands, M ALU result,
//   W data/rd/we/valid.
module datapath_pipe
  import proc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              d_valid_i,
  input  logic [REG_AW-1:0] d_rs1_i,
  input  logic [REG_AW-1:0] d_rs2_i,
  input  logic [REG_AW-1:0] d_rd_i,
  input  logic              d_rd_we_i,
  input  logic              d_is_load_i,
  input  logic [XLEN-1:0]   reg1_data_i,
  input  logic [XLEN-1:0]   reg2_data_i,
  input  logic [XLEN-1:0]   imm_signed_i,
  input  logic [XLEN-1:0]   pc_val_d1_i,
  input  logic [XLEN-1:0]   pc_val_d2_i,
  input  op1_mux_sel_t      d_op1_mux_sel_i,
  input  op1_mux_sel_t      d_arith_op1_mux_sel_i,
  input  op2_mux_sel_t      d_op2_mux_sel_i,
  input  op2_mux_sel_t      d_arith_op2_mux_sel_i,
  input  alu_mux_sel_t      alu_mux_sel_i,
  input  w_mux_sel_t        w_mux_sel_i,
  input  logic [XLEN-1:0]   arith_out_i,
  input  logic [XLEN-1:0]   logical_out_i,
  input  logic [XLEN-1:0]   shift_out_i,
  input  logic [XLEN-1:0]   csr_val_i,
  input  logic [2:0]        m_load_funct3_i,
  input  logic [XLEN-1:0]   m_dm_dout_i,
  output logic [XLEN-1:0]   x_op1_o,
  output logic [XLEN-1:0]   x_op2_o,
  output logic [XLEN-1:0]   x_arith_op1_o,
  output logic [XLEN-1:0]   x_arith_op2_o,
  output logic [XLEN-1:0]   m_alu_data_o,
  output logic [XLEN-1:0]   w_mux_o,
  output logic [REG_AW-1:0] w_rd_o,
  output logic              w_rd_we_o,
  output logic              w_valid_o
);

  localparam int BYTE_AW = $clog2(XLEN/8);

  logic              x_valid_q, x_we_q, x_is_load_q;
  logic [REG_AW-1:0] x_rd_q;
  logic [XLEN-1:0]   x_op1_q, x_op2_q, x_aop1_q, x_aop2_q;
  logic              m_valid_q, m_we_q;
  logic [REG_AW-1:0] m_rd_q;
  logic [XLEN-1:0]   m_alu_data_q;
  logic              w_valid_q, w_we_q;
  logic [REG_AW-1:0] w_rd_q;
  logic [XLEN-1:0]   w_mux_q;

  logic [XLEN-1:0]   m_alu_data_next, w_mux_next, load_data;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  fwd_sel_t          fwd1, fwd2;
  logic              advance;

  // Youngest matching writer wins; a load still in X has no data yet.
  function automatic fwd_sel_t fwd_pick(
    input logic [REG_AW-1:0] rs,
    input logic xv, input logic xw, input logic xl, input logic [REG_AW-1:0] xr,
    input logic mv, input logic mw, input logic [REG_AW-1:0] mr,
    input logic wv, input logic ww, input logic [REG_AW-1:0] wr
  );
    fwd_pick = FWD_NONE;
    if (rs != '0) begin
      if (xv && xw && !xl && xr == rs) fwd_pick = FWD_X;
      else if (mv && mw && mr == rs)   fwd_pick = FWD_M;
      else if (wv && ww && wr == rs)   fwd_pick = FWD_W;
    end
  endfunction

  always_comb begin
    fwd1 = fwd_pick(d_rs1_i, x_valid_q, x_we_q, x_is_load_q, x_rd_q,
                    m_valid_q, m_we_q, m_rd_q, w_valid_q, w_we_q, w_rd_q);
    fwd2 = fwd_pick(d_rs2_i, x_valid_q, x_we_q, x_is_load_q, x_rd_q,
                    m_valid_q, m_we_q, m_rd_q, w_valid_q, w_we_q, w_rd_q);
    case (fwd1)
      FWD_X:   rs1_val = m_alu_data_next;
      FWD_M:   rs1_val = w_mux_next;
      FWD_W:   rs1_val = w_mux_q;
      default: rs1_val = reg1_data_i;
    endcase
    case (fwd2)
      FWD_X:   rs2_val = m_alu_data_next;
      FWD_M:   rs2_val = w_mux_next;
      FWD_W:   rs2_val = w_mux_q;
      default: rs2_val = reg2_data_i;
    endcase
  end

  always_comb begin
    m_alu_data_next = '0;
    case (alu_mux_sel_i)
      ALU_ARITH:            m_alu_data_next = arith_out_i;
      ALU_LOGIC:            m_alu_data_next = logical_out_i;
      ALU_SHIFT:            m_alu_data_next = shift_out_i;
      ALU_X_OP1:            m_alu_data_next = x_op1_q;
      ALU_PC_VAL_D2:        m_alu_data_next = pc_val_d2_i;
      ALU_PC_VAL_PLUS_4_D2: m_alu_data_next = pc_val_d2_i + XLEN'(4);
      default:              m_alu_data_next = '0;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (m_load_funct3_i),
    .offset (m_alu_data_q[BYTE_AW-1:0]),
    .word   (m_dm_dout_i),
    .data   (load_data)
  );

  always_comb begin
    w_mux_next = '0;
    case (w_mux_sel_i)
      W_ALU:   w_mux_next = m_alu_data_q;
      W_DM:    w_mux_next = load_data;
      W_CSR:   w_mux_next = csr_val_i;
      default: w_mux_next = '0;
    endcase
  end

  // A flush must let W retire the M instruction even while stalled.
  assign advance = !stall_i || flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_valid_q    <= 1'b0;
      x_we_q       <= 1'b0;
      x_is_load_q  <= 1'b0;
      x_rd_q       <= '0;
      x_op1_q      <= '0;
      x_op2_q      <= '0;
      x_aop1_q     <= '0;
      x_aop2_q     <= '0;
      m_valid_q    <= 1'b0;
      m_we_q       <= 1'b0;
      m_rd_q       <= '0;
      m_alu_data_q <= '0;
      w_valid_q    <= 1'b0;
      w_we_q       <= 1'b0;
      w_rd_q       <= '0;
      w_mux_q      <= '0;
    end else if (advance) begin
      x_valid_q    <= d_valid_i && !flush_i;
      x_we_q       <= d_rd_we_i;
      x_is_load_q  <= d_is_load_i;
      x_rd_q       <= d_rd_i;
      x_op1_q      <= (d_op1_mux_sel_i == REG1_DATA) ? rs1_val : pc_val_d1_i;
      x_aop1_q     <= (d_arith_op1_mux_sel_i == REG1_DATA) ? rs1_val : pc_val_d1_i;
      x_op2_q      <= (d_op2_mux_sel_i == REG2_DATA) ? rs2_val : imm_signed_i;
      x_aop2_q     <= (d_arith_op2_mux_sel_i == REG2_DATA) ? rs2_val : imm_signed_i;
      m_valid_q    <= x_valid_q && !flush_i;
      m_we_q       <= x_we_q;
      m_rd_q       <= x_rd_q;
      m_alu_data_q <= m_alu_data_next;
      w_valid_q    <= m_valid_q;
      w_we_q       <= m_we_q;
      w_rd_q       <= m_rd_q;
      w_mux_q      <= w_mux_next;
    end
  end

  assign x_op1_o       = x_op1_q;
  assign x_op2_o       = x_op2_q;
  assign x_arith_op1_o = x_aop1_q;
  assign x_arith_op2_o = x_aop2_q;
  assign m_alu_data_o  = m_alu_data_q;
  assign w_mux_o       = w_mux_q;
  assign w_rd_o        = w_rd_q;
  assign w_rd_we_o     = w_valid_q && w_we_q;
  assign w_valid_o     = w_valid_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: drives an XLEN=64 and an XLEN=32 instance from shared
// stimulus and compares both against an instruction-record pipeline model.
module tb_datapath_pipe;
  import proc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, stall, flush, d_valid, d_rd_we, d_is_load;
  logic [4:0]   rs1, rs2, rd;
  logic [63:0]  reg1, reg2, imm, pc1, pc2, arith, lgc, shf, csr, dout;
  logic [2:0]   f3;
  op1_mux_sel_t op1_sel, aop1_sel;
  op2_mux_sel_t op2_sel, aop2_sel;
  alu_mux_sel_t alu_sel;
  w_mux_sel_t   w_sel;

  logic [63:0] o64_x_op1, o64_x_op2, o64_x_aop1, o64_x_aop2, o64_m_alu, o64_w_mux;
  logic [31:0] o32_x_op1, o32_x_op2, o32_x_aop1, o32_x_aop2, o32_m_alu, o32_w_mux;
  logic [4:0]  o64_w_rd, o32_w_rd;
  logic        o64_w_we, o32_w_we, o64_w_valid, o32_w_valid;

  datapath_pipe #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .d_valid_i(d_valid), .d_rs1_i(rs1), .d_rs2_i(rs2), .d_rd_i(rd),
    .d_rd_we_i(d_rd_we), .d_is_load_i(d_is_load),
    .reg1_data_i(reg1), .reg2_data_i(reg2), .imm_signed_i(imm),
    .pc_val_d1_i(pc1), .pc_val_d2_i(pc2),
    .d_op1_mux_sel_i(op1_sel), .d_arith_op1_mux_sel_i(aop1_sel),
    .d_op2_mux_sel_i(op2_sel), .d_arith_op2_mux_sel_i(aop2_sel),
    .alu_mux_sel_i(alu_sel), .w_mux_sel_i(w_sel),
    .arith_out_i(arith), .logical_out_i(lgc), .shift_out_i(shf), .csr_val_i(csr),
    .m_load_funct3_i(f3), .m_dm_dout_i(dout),
    .x_op1_o(o64_x_op1), .x_op2_o(o64_x_op2),
    .x_arith_op1_o(o64_x_aop1), .x_arith_op2_o(o64_x_aop2),
    .m_alu_data_o(o64_m_alu), .w_mux_o(o64_w_mux), .w_rd_o(o64_w_rd),
    .w_rd_we_o(o64_w_we), .w_valid_o(o64_w_valid)
  );

  datapath_pipe #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .d_valid_i(d_valid), .d_rs1_i(rs1), .d_rs2_i(rs2), .d_rd_i(rd),
    .d_rd_we_i(d_rd_we), .d_is_load_i(d_is_load),
    .reg1_data_i(reg1[31:0]), .reg2_data_i(reg2[31:0]), .imm_signed_i(imm[31:0]),
    .pc_val_d1_i(pc1[31:0]), .pc_val_d2_i(pc2[31:0]),
    .d_op1_mux_sel_i(op1_sel), .d_arith_op1_mux_sel_i(aop1_sel),
    .d_op2_mux_sel_i(op2_sel), .d_arith_op2_mux_sel_i(aop2_sel),
    .alu_mux_sel_i(alu_sel), .w_mux_sel_i(w_sel),
    .arith_out_i(arith[31:0]), .logical_out_i(lgc[31:0]), .shift_out_i(shf[31:0]),
    .csr_val_i(csr[31:0]), .m_load_funct3_i(f3), .m_dm_dout_i(dout[31:0]),
    .x_op1_o(o32_x_op1), .x_op2_o(o32_x_op2),
    .x_arith_op1_o(o32_x_aop1), .x_arith_op2_o(o32_x_aop2),
    .m_alu_data_o(o32_m_alu), .w_mux_o(o32_w_mux), .w_rd_o(o32_w_rd),
    .w_rd_we_o(o32_w_we), .w_valid_o(o32_w_valid)
  );

  // One instruction as seen by the model: its tags, its captured operands,
  // the ALU result it carries out of X, and the writeback value out of M.
  typedef struct {
    bit          valid;
    bit [4:0]    rd;
    bit          we;
    bit          ld;
    logic [63:0] op1, op2, aop1, aop2, alu, wb;
  } rec_t;

  rec_t xs[2], ms[2], ws[2];   // index 0: XLEN=64, index 1: XLEN=32
  int checks = 0;
  int fails  = 0;

  function automatic logic [63:0] msk(input int xl, input logic [63:0] v);
    return (xl == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
  endfunction

  function automatic logic [63:0] sx(input int xl, input logic [63:0] v, input int bits);
    logic [63:0] keep = (64'd1 << bits) - 64'd1;
    logic [63:0] r = v & keep;
    if (r[bits-1]) r = r | ~keep;
    return msk(xl, r);
  endfunction

  function automatic logic [63:0] load_ref(input int xl, input logic [2:0] fn,
                                           input logic [63:0] addr, input logic [63:0] word);
    int nb = xl / 8;
    int off = int'(addr % 64'(nb));
    logic [63:0] d = msk(xl, word);
    logic [63:0] b = (d >> (8 * off)) & 64'hFF;
    logic [63:0] h = (d >> (8 * ((off / 2) * 2))) & 64'hFFFF;
    logic [63:0] w = (d >> (8 * ((off / 4) * 4))) & 64'hFFFF_FFFF;
    case (fn)
      3'b000:  return sx(xl, b, 8);
      3'b001:  return sx(xl, h, 16);
      3'b010:  return sx(xl, w, 32);
      3'b011:  return (xl == 64) ? d : sx(xl, w, 32);
      3'b100:  return b;
      3'b101:  return h;
      3'b110:  return (xl == 64) ? w : sx(xl, w, 32);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] alu_ref(input int xl, input int sel, input logic [63:0] xop1);
    case (sel)
      0:       return msk(xl, arith);
      1:       return msk(xl, lgc);
      2:       return msk(xl, shf);
      3:       return xop1;
      4:       return msk(xl, pc2);
      5:       return msk(xl, pc2 + 64'd4);
      default: return 64'd0;
    endcase
  endfunction

  // Value a reader of rs should see: newest in-flight writer, else the regfile.
  function automatic logic [63:0] resolve(input int k, input logic [4:0] rs,
                                          input logic [63:0] rf, input logic [63:0] alu_now,
                                          input logic [63:0] wb_now);
    if (rs == 5'd0) return rf;
    if (xs[k].valid && xs[k].we && !xs[k].ld && xs[k].rd == rs) return alu_now;
    if (ms[k].valid && ms[k].we && ms[k].rd == rs) return wb_now;
    if (ws[k].valid && ws[k].we && ws[k].rd == rs) return ws[k].wb;
    return rf;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int          xl;
      rec_t        nx, nm, nw;
      logic [63:0] alu_now, wb_now, rv1, rv2;
      xl = (k == 0) ? 64 : 32;
      if (rst) begin
        xs[k] = '{default: '0};
        ms[k] = '{default: '0};
        ws[k] = '{default: '0};
      end else if (!stall || flush) begin
        alu_now = alu_ref(xl, int'(alu_sel), xs[k].op1);
        case (int'(w_sel))
          0:       wb_now = ms[k].alu;
          1:       wb_now = load_ref(xl, f3, ms[k].alu, dout);
          2:       wb_now = msk(xl, csr);
          default: wb_now = 64'd0;
        endcase
        rv1 = resolve(k, rs1, msk(xl, reg1), alu_now, wb_now);
        rv2 = resolve(k, rs2, msk(xl, reg2), alu_now, wb_now);
        nx = '{default: '0};
        nx.valid = d_valid && !flush;
        nx.rd    = rd;
        nx.we    = d_rd_we;
        nx.ld    = d_is_load;
        nx.op1   = (op1_sel  == REG1_DATA) ? rv1 : msk(xl, pc1);
        nx.aop1  = (aop1_sel == REG1_DATA) ? rv1 : msk(xl, pc1);
        nx.op2   = (op2_sel  == REG2_DATA) ? rv2 : msk(xl, imm);
        nx.aop2  = (aop2_sel == REG2_DATA) ? rv2 : msk(xl, imm);
        nm = xs[k];
        nm.valid = xs[k].valid && !flush;
        nm.alu   = alu_now;
        nw = ms[k];
        nw.wb = wb_now;
        xs[k] = nx;
        ms[k] = nm;
        ws[k] = nw;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("x_op1_64",  o64_x_op1,  xs[0].op1);
    chk("x_op2_64",  o64_x_op2,  xs[0].op2);
    chk("x_aop1_64", o64_x_aop1, xs[0].aop1);
    chk("x_aop2_64", o64_x_aop2, xs[0].aop2);
    chk("m_alu_64",  o64_m_alu,  ms[0].alu);
    chk("w_mux_64",  o64_w_mux,  ws[0].wb);
    chk("w_rd_64",   64'(o64_w_rd), 64'(ws[0].rd));
    chk("w_flags_64", {62'd0, o64_w_we, o64_w_valid},
        {62'd0, ws[0].valid && ws[0].we, ws[0].valid});
    chk("x_op1_32",  64'(o32_x_op1),  xs[1].op1);
    chk("x_op2_32",  64'(o32_x_op2),  xs[1].op2);
    chk("x_aop1_32", 64'(o32_x_aop1), xs[1].aop1);
    chk("x_aop2_32", 64'(o32_x_aop2), xs[1].aop2);
    chk("m_alu_32",  64'(o32_m_alu),  ms[1].alu);
    chk("w_mux_32",  64'(o32_w_mux),  ws[1].wb);
    chk("w_rd_32",   64'(o32_w_rd),   64'(ws[1].rd));
    chk("w_flags_32", {62'd0, o32_w_we, o32_w_valid},
        {62'd0, ws[1].valid && ws[1].we, ws[1].valid});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    rst = 0; stall = 0; flush = 0;
    d_valid = 0; d_rd_we = 0; d_is_load = 0;
    rs1 = 0; rs2 = 0; rd = 0;
    reg1 = 64'hDEAD; reg2 = 0; imm = 0; pc1 = 0; pc2 = 0;
    arith = 0; lgc = 0; shf = 0; csr = 0; dout = 0; f3 = 0;
    op1_sel = REG1_DATA; aop1_sel = REG1_DATA;
    op2_sel = REG2_DATA; aop2_sel = REG2_DATA;
    alu_sel = ALU_ARITH; w_sel = W_ALU;
  endtask

  task automatic rand_inputs();
    rst       = ($urandom_range(0, 49) == 0);
    stall     = ($urandom_range(0, 4) == 0);
    flush     = ($urandom_range(0, 9) == 0);
    d_valid   = ($urandom_range(0, 3) != 0);
    d_rd_we   = ($urandom_range(0, 3) != 0);
    d_is_load = ($urandom_range(0, 3) == 0);
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    reg1 = {$urandom, $urandom}; reg2 = {$urandom, $urandom};
    imm  = {$urandom, $urandom}; pc1  = {$urandom, $urandom};
    pc2  = {$urandom, $urandom}; arith = {$urandom, $urandom};
    lgc  = {$urandom, $urandom}; shf  = {$urandom, $urandom};
    csr  = {$urandom, $urandom}; dout = {$urandom, $urandom};
    f3   = 3'($urandom_range(0, 7));
    op1_sel  = op1_mux_sel_t'($urandom_range(0, 1));
    aop1_sel = op1_mux_sel_t'($urandom_range(0, 1));
    op2_sel  = op2_mux_sel_t'($urandom_range(0, 1));
    aop2_sel = op2_mux_sel_t'($urandom_range(0, 1));
    alu_sel  = alu_mux_sel_t'($urandom_range(0, 7));
    w_sel    = w_mux_sel_t'($urandom_range(0, 2));
  endtask

  // Producer writes r with ALU result 0x10; consumer reads r via rs1 `gap`
  // instructions later, with non-writing fillers in between.
  task automatic fwd_case(input string tag, input int gap, input logic [4:0] r,
                          input logic [63:0] exp);
    quiet(); d_valid = 1; rd = r; d_rd_we = 1;
    cycle();
    for (int i = 0; i < gap; i++) begin
      quiet();
      arith = (i == 0) ? 64'h10 : 64'h99;
      d_valid = 1;
      rd = 5'd9;
      if (i == gap - 1) rs1 = r;
      cycle();
    end
    chk(tag, o64_x_op1, exp);
    chk(tag, 64'(o32_x_op1), exp);
  endtask

  task automatic load_case(input string tag, input logic [63:0] addr, input logic [2:0] fn,
                           input logic [63:0] word, input logic [63:0] e64,
                           input logic [63:0] e32);
    quiet(); arith = addr;
    cycle();
    quiet(); f3 = fn; dout = word; w_sel = W_DM;
    cycle();
    chk(tag, o64_w_mux, e64);
    chk(tag, 64'(o32_w_mux), e32);
  endtask

  initial begin
    quiet();
    rand_inputs(); rst = 1;
    cycle();
    rand_inputs(); rst = 1;
    cycle();
    chk("rst_w_mux", o64_w_mux, 64'd0);
    chk("rst_w_valid", {62'd0, o64_w_valid, o32_w_valid}, 64'd0);
    chk("rst_x_op1", 64'(o32_x_op1), 64'd0);

    fwd_case("fwd_from_x", 1, 5'd5, 64'h10);
    fwd_case("fwd_from_m", 2, 5'd5, 64'h10);
    fwd_case("fwd_from_w", 3, 5'd5, 64'h10);
    fwd_case("fwd_x0", 1, 5'd0, 64'hDEAD);

    load_case("ld_lb_off7", 64'h7, LOAD_B, 64'h8877_6655_4433_2211,
              64'hFFFF_FFFF_FFFF_FF88, 64'h44);
    load_case("ld_lhu_off6", 64'h6, LOAD_HU, 64'h8877_6655_4433_2211,
              64'h8877, 64'h4433);
    load_case("ld_lwu_off4", 64'h4, LOAD_WU, 64'h8877_6655_4433_2211,
              64'h8877_6655, 64'h4433_2211);
    load_case("ld_ld", 64'h1000, LOAD_D, 64'h8877_6655_4433_2211,
              64'h8877_6655_4433_2211, 64'h4433_2211);
    load_case("ld_lh_off2", 64'h2, LOAD_H, 64'h8000_7F00,
              64'hFFFF_FFFF_FFFF_8000, 64'hFFFF_8000);
    load_case("ld_lbu_off1", 64'h1, LOAD_BU, 64'h8000_7F00, 64'h7F, 64'h7F);

    quiet(); alu_sel = ALU_PC_VAL_PLUS_4_D2; pc2 = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    chk("pc_plus4_wrap", o64_m_alu, 64'd0);
    chk("pc_plus4_wrap", 64'(o32_m_alu), 64'd0);

    // Three writers rd=1,2,3 in flight, then a long stall, then flush+stall.
    for (int i = 1; i <= 3; i++) begin
      quiet(); d_valid = 1; rd = 5'(i); d_rd_we = 1;
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      rand_inputs(); rst = 0; flush = 0; stall = 1;
      cycle();
      chk("stall_w_rd", 64'(o64_w_rd), 64'd1);
      chk("stall_w_we", {63'd0, o32_w_we}, 64'd1);
    end
    rand_inputs(); rst = 0; stall = 1; flush = 1;
    cycle();
    chk("flush_retire_rd", 64'(o64_w_rd), 64'd2);
    chk("flush_retire_we", {62'd0, o64_w_we, o32_w_we}, 64'd3);
    quiet(); d_valid = 1; rs1 = 5'd3; reg1 = 64'hBEEF; rd = 5'd7;
    cycle();
    chk("flush_no_fwd", o64_x_op1, 64'hBEEF);
    chk("flush_bubble1", {62'd0, o64_w_we, o32_w_we}, 64'd0);
    quiet();
    cycle();
    chk("flush_bubble2", {62'd0, o64_w_we, o32_w_we}, 64'd0);

    rand_inputs(); stall = 1; flush = 0; rst = 1;
    cycle();
    chk("rst_in_stall", o64_m_alu | 64'(o32_x_op2), 64'd0);
    chk("rst_in_stall_v", {62'd0, o64_w_valid, o32_w_valid}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
